reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_file.sv
// Two-read, one-write register file with x0 hardwired to zero.
// Write-first bypass, saturating write counter and a sequential clear engine.
module reg_file #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            reg_write,
    input  logic            clear_req,
    output logic [XLEN-1:0] rd_data_1,
    output logic [XLEN-1:0] rd_data_2,
    output logic            busy,
    output logic            clear_done,
    output logic [15:0]     write_count
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   ptr, ptr_nx;
    logic            done_nx;
    logic            wr_en;
    logic [XLEN-1:0] regs [NREGS];

    assign wr_en = reg_write && (rd_addr != '0) && !busy;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        busy     = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                    ptr_nx   = AW'(1);
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                ptr_nx = ptr + AW'(1);
                if (ptr == AW'(NREGS - 1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            clear_done <= done_nx;
        end
    end

    // x0 is never targeted: writes skip it and the clear starts at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (busy) begin
            regs[ptr] <= '0;
        end else if (wr_en) begin
            regs[rd_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_count <= '0;
        end else if (wr_en && (write_count != 16'hFFFF)) begin
            write_count <= write_count + 16'd1;
        end
    end

    always_comb begin
        rd_data_1 = '0;
        if (rs1_addr != '0) begin
            if (wr_en && (rd_addr == rs1_addr)) begin
                rd_data_1 = wr_data;
            end else begin
                rd_data_1 = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rd_data_2 = '0;
        if (rs2_addr != '0) begin
            if (wr_en && (rd_addr == rs2_addr)) begin
                rd_data_2 = wr_data;
            end else begin
                rd_data_2 = regs[rs2_addr];
            end
        end
    end

endmodule
